// File: rtl/button_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : button_scan_ctrl
// Purpose  : Shared debounce engine and event scheduler for front-panel
//            buttons. A local prescaler generates a sample tick; on each tick
//            one stability-counter datapath is time-multiplexed across all
//            buttons (one button per clk, ascending index). Accepted
//            transitions are queued in a small FIFO popped via valid/ready.
// Ports    : clk          - system clock, rising edge
//            rst          - asynchronous active-low reset
//            btn_in       - raw asynchronous button levels [N_BTN]
//            tick         - one-clk sample strobe
//            db_state     - debounced button levels [N_BTN]
//            ev_valid     - event FIFO non-empty
//            ev_id        - button index of head event
//            ev_edge      - 1 = press, 0 = release
//            ev_ready     - consumer pop request
//            ev_overflow  - sticky: event dropped because FIFO full
//            ev_clr       - clears ev_overflow
// Options  : RELEASE_EV_EN - when defined, releases are queued as events too
//            and the FIFO stores the edge bit; otherwise only presses are
//            queued and ev_edge is constant 1.
// Revision : 1.0 - initial release
// ============================================================================
module button_scan_ctrl #(
    parameter int N_BTN      = 4,
    parameter int TICK_DIV   = 4,
    parameter int STABLE_CNT = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [N_BTN-1:0]                            btn_in,
    output logic                                        tick,
    output logic [N_BTN-1:0]                            db_state,
    output logic                                        ev_valid,
    output logic [((N_BTN > 1) ? $clog2(N_BTN) : 1)-1:0] ev_id,
    output logic                                        ev_edge,
    input  logic                                        ev_ready,
    output logic                                        ev_overflow,
    input  logic                                        ev_clr
);

    localparam int C_ID_W  = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int C_CNT_W = $clog2(STABLE_CNT + 1);
    localparam int C_PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int C_PTR_W = $clog2(FIFO_DEPTH);
`ifdef RELEASE_EV_EN
    localparam int C_ENT_W = C_ID_W + 1;
`else
    localparam int C_ENT_W = C_ID_W;
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [C_PS_W-1:0]                    presc_q, presc_d;
    logic [N_BTN-1:0]                     sync1_q, sync2_q;
    state_t                               state_q, state_d;
    logic [C_ID_W-1:0]                    idx_q, idx_d;
    logic [N_BTN-1:0][C_CNT_W-1:0]        cnt_q, cnt_d;
    logic [N_BTN-1:0]                     db_q, db_d;
    logic [FIFO_DEPTH-1:0][C_ENT_W-1:0]   mem_q, mem_d;
    logic [C_PTR_W:0]                     wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W:0]                     rd_ptr_q, rd_ptr_d;
    logic                                 ovf_q, ovf_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                                 w_tick;
    logic                                 w_s;
    logic [C_CNT_W-1:0]                   w_cnt_inc;
    logic                                 w_accept;
    logic                                 w_push;
    logic                                 w_empty;
    logic                                 w_full;
    logic                                 w_pop;
    logic                                 w_wr;
    logic                                 w_drop;
    logic [C_ENT_W-1:0]                   w_entry;
    logic [C_ENT_W-1:0]                   w_head;

    assign w_tick    = (presc_q == C_PS_W'(TICK_DIV - 1));
    assign w_s       = sync2_q[idx_q];
    assign w_cnt_inc = cnt_q[idx_q] + 1'b1;

    // Prescaler: 0..TICK_DIV-1, wrapping
    always_comb begin
        presc_d = presc_q + 1'b1;
        if (w_tick) begin
            presc_d = '0;
        end
    end

    // Scan FSM. When TICK_DIV == N_BTN the next tick lands on the last scan
    // slot; the scan then restarts directly so no tick is ever lost.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (w_tick) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                if (idx_q == C_ID_W'(N_BTN - 1)) begin
                    state_d = w_tick ? S_SCAN : S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Shared stability counter datapath, applied to button idx_q
    always_comb begin
        cnt_d    = cnt_q;
        db_d     = db_q;
        w_accept = 1'b0;
        if (state_q == S_SCAN) begin
            if (w_s == db_q[idx_q]) begin
                cnt_d[idx_q] = '0;
            end else if (w_cnt_inc < C_CNT_W'(STABLE_CNT)) begin
                cnt_d[idx_q] = w_cnt_inc;
            end else begin
                db_d[idx_q]  = w_s;
                cnt_d[idx_q] = '0;
                w_accept     = 1'b1;
            end
        end
    end

`ifdef RELEASE_EV_EN
    assign w_push  = w_accept;
    assign w_entry = {w_s, idx_q};
    assign ev_edge = w_head[C_ID_W];
`else
    // Releases update db_state silently
    assign w_push  = w_accept & w_s;
    assign w_entry = idx_q;
    assign ev_edge = 1'b1;
`endif

    // Event FIFO: pointers carry one extra wrap bit to tell full from empty
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[C_PTR_W] != rd_ptr_q[C_PTR_W]) &&
                     (wr_ptr_q[C_PTR_W-1:0] == rd_ptr_q[C_PTR_W-1:0]);
    assign w_pop   = !w_empty && ev_ready;
    // A pop in the same clk frees the slot, so a push into a full FIFO survives
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;
    assign w_head  = mem_q[rd_ptr_q[C_PTR_W-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_wr) begin
            mem_d[wr_ptr_q[C_PTR_W-1:0]] = w_entry;
            wr_ptr_d                     = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Sticky overflow; a new drop wins over a simultaneous clear
    always_comb begin
        ovf_d = ovf_q;
        if (ev_clr) begin
            ovf_d = 1'b0;
        end
        if (w_drop) begin
            ovf_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q  <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            db_q     <= '0;
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            sync1_q  <= btn_in;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tick        = w_tick;
    assign db_state    = db_q;
    assign ev_valid    = !w_empty;
    assign ev_id       = w_head[C_ID_W-1:0];
    assign ev_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_button_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_scan_ctrl
// Purpose  : Self-checking bench for button_scan_ctrl. A reference model
//            tracks elapsed clocks since reset and derives tick times, scan
//            slots and debounce decisions arithmetically; accepted events go
//            into a scoreboard queue that a negedge monitor compares against
//            the DUT's FIFO head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_scan_ctrl;

    localparam int N_BTN      = 4;
    localparam int TICK_DIV   = 4;
    localparam int STABLE_CNT = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int ID_W       = 2;
`ifdef RELEASE_EV_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N_BTN-1:0]  btn_in = '0;
    logic              ev_ready = 1'b0;
    logic              ev_clr = 1'b0;
    logic              tick;
    logic [N_BTN-1:0]  db_state;
    logic              ev_valid;
    logic [ID_W-1:0]   ev_id;
    logic              ev_edge;
    logic              ev_overflow;

    button_scan_ctrl #(
        .N_BTN      (N_BTN),
        .TICK_DIV   (TICK_DIV),
        .STABLE_CNT (STABLE_CNT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .tick        (tick),
        .db_state    (db_state),
        .ev_valid    (ev_valid),
        .ev_id       (ev_id),
        .ev_edge     (ev_edge),
        .ev_ready    (ev_ready),
        .ev_overflow (ev_overflow),
        .ev_clr      (ev_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int               m_n;          // rising edges since reset release
    bit [N_BTN-1:0]   m_s1, m_s2;   // btn_in delayed by 1 and 2 edges
    bit [N_BTN-1:0]   m_db;
    int               m_cnt [N_BTN];
    int               m_occ;
    bit               m_ovf;
    bit               m_tick;
    int               exp_q [$];    // id*2 + edge

    always @(posedge clk or negedge rst) begin
        int r;
        int idx;
        bit pop;
        bit acc;
        bit drop;
        bit sv;
        if (!rst) begin
            m_n   = 0;
            m_s1  = '0;
            m_s2  = '0;
            m_db  = '0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_occ = 0;
            m_ovf = 1'b0;
            m_tick = 1'b0;
            exp_q.delete();
        end else begin
            // Tick when the edge count is TICK_DIV-1 mod TICK_DIV; button i
            // is examined i+1 edges after that tick.
            r    = m_n % TICK_DIV;
            pop  = (m_occ > 0) && ev_ready;
            acc  = 1'b0;
            drop = 1'b0;
            idx  = r;
            sv   = 1'b0;
            if (m_n >= TICK_DIV && r < N_BTN) begin
                sv = m_s2[idx];
                if (sv == m_db[idx]) begin
                    m_cnt[idx] = 0;
                end else if (m_cnt[idx] + 1 < STABLE_CNT) begin
                    m_cnt[idx] = m_cnt[idx] + 1;
                end else begin
                    m_db[idx]  = sv;
                    m_cnt[idx] = 0;
                    acc        = sv || REL;
                end
            end
            if (pop) m_occ = m_occ - 1;
            if (acc) begin
                if (m_occ < FIFO_DEPTH) begin
                    m_occ = m_occ + 1;
                    exp_q.push_back(idx * 2 + (REL ? int'(sv) : 1));
                end else begin
                    drop = 1'b1;
                end
            end
            if (ev_clr) m_ovf = 1'b0;
            if (drop)   m_ovf = 1'b1;
            m_s2   = m_s1;
            m_s1   = btn_in;
            m_n    = m_n + 1;
            m_tick = ((m_n % TICK_DIV) == TICK_DIV - 1);
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares on the falling edge, pops the scoreboard on handshake
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        int head;
        cmp("tick", int'(tick), int'(m_tick));
        cmp("db_state", int'(db_state), int'(m_db));
        cmp("ev_valid", int'(ev_valid), int'(m_occ > 0));
        cmp("ev_overflow", int'(ev_overflow), int'(m_ovf));
        if (m_occ > 0) begin
            if (exp_q.size() == 0) begin
                cmp("scoreboard_depth", 0, 1);
            end else begin
                head = exp_q[0];
                cmp("ev_id", int'(ev_id), head / 2);
                cmp("ev_edge", int'(ev_edge), head % 2);
                if (ev_ready) exp_q.pop_front();
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        ev_ready = 1'b1;
        cyc(FIFO_DEPTH + 2);
        ev_ready = 1'b0;
    endtask

    initial begin
        int waited;
        // Reset with all buttons asserted
        rst    = 1'b0;
        btn_in = '1;
        cyc(3);
        cmp("rst_db_state", int'(db_state), 0);
        cmp("rst_ev_valid", int'(ev_valid), 0);
        cmp("rst_tick", int'(tick), 0);
        cmp("rst_ev_id", int'(ev_id), 0);
        btn_in = '0;
        rst    = 1'b1;
        cyc(12);

        // Glitch on button 0: too short to be accepted
        btn_in[0] = 1'b1;
        cyc(6);
        btn_in[0] = 1'b0;
        cyc(30);

        // Clean press on button 2, then one-clk pop
        btn_in[2] = 1'b1;
        cyc(30);
        ev_ready = 1'b1;
        cyc(1);
        ev_ready = 1'b0;
        cyc(6);

        // Simultaneous press on buttons 3 and 0
        btn_in[3] = 1'b1;
        btn_in[0] = 1'b1;
        cyc(30);
        drain();
        btn_in = '0;
        cyc(30);
        drain();

        // Overflow: four presses, release all, fifth press dropped
        for (int b = 0; b < N_BTN; b++) begin
            btn_in[b] = 1'b1;
            cyc(20);
        end
        btn_in = '0;
        cyc(30);
        btn_in[1] = 1'b1;
        cyc(30);
        ev_clr = 1'b1;
        cyc(1);
        ev_clr = 1'b0;
        cyc(2);
        drain();
        btn_in = '0;
        cyc(30);
        drain();

        // Reset mid-operation: two queued events and cnt[1] == 2
        btn_in[0] = 1'b1;
        btn_in[2] = 1'b1;
        cyc(30);
        btn_in[1] = 1'b1;
        waited = 0;
        while (m_cnt[1] != 2 && waited < 100) begin
            cyc(1);
            waited++;
        end
        cmp("cnt1_reached_2", int'(waited < 100), 1);
        #2;
        rst = 1'b0;
        #1;
        cmp("async_rst_ev_valid", int'(ev_valid), 0);
        cmp("async_rst_db_state", int'(db_state), 0);
        cmp("async_rst_ev_overflow", int'(ev_overflow), 0);
        cyc(2);
        rst = 1'b1;
        cyc(40);
        drain();
        btn_in = '0;
        cyc(30);
        drain();

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                int b;
                b = $urandom_range(0, N_BTN - 1);
                btn_in[b] = ~btn_in[b];
            end
            ev_ready = ($urandom_range(0, 3) == 0);
            ev_clr   = ($urandom_range(0, 49) == 0);
            if (c == 1500) begin
                #($urandom_range(1, 7));
                rst = 1'b0;
                cyc(2);
                rst = 1'b1;
            end
            cyc(1);
        end
        ev_ready = 1'b0;
        ev_clr   = 1'b0;
        cyc(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
